// File: rtl/turbo_encoder.sv
// Rate-1/3 turbo encoder: two RSC (13,15 octal) encoders and a QPP interleaver over a K-bit buffer; TURBO_ENC_TAIL_EN adds trellis termination.
// Latency: beat 0 is valid the cycle after the K-th accepted input bit; K beats per block, or K+6 with the macro.
// Backpressure: input is accepted only while loading; while out_ready_i is low all state and outputs hold.
module turbo_encoder #(
    parameter int K  = 40,
    parameter int F1 = 3,
    parameter int F2 = 10
) (
    input  logic clk_p_i,
    input  logic reset_n_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  logic data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output logic sys_o,
    output logic par1_o,
    output logic par2_o,
    output logic last_o
);

    localparam int CW   = $clog2(K);
    localparam int G0_I = (F1 + F2) % K;
    localparam int GS_I = (2 * F2) % K;
    localparam int KM1  = K - 1;

    localparam logic [CW:0]   K_X    = K[CW:0];
    localparam logic [CW-1:0] K_LO   = K[CW-1:0];
    localparam logic [CW-1:0] K_LAST = KM1[CW-1:0];
    localparam logic [CW-1:0] G0     = G0_I[CW-1:0];
    localparam logic [CW-1:0] G_STEP = GS_I[CW-1:0];

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] ENC   = 3'd2;
`ifdef TURBO_ENC_TAIL_EN
    localparam logic [2:0] TAIL1 = 3'd3;
    localparam logic [2:0] TAIL2 = 3'd4;
`endif

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] pi_q;
    logic [CW-1:0] g_q;
    // Tap order: [0] = d1, [1] = d2, [2] = d3
    logic [2:0]    r1;
    logic [2:0]    r2;
    logic [K-1:0]  data_buf;

    logic          u1, u2, a1, a2, z1, z2;
    logic [CW:0]   pi_sum, g_sum;
    logic [CW-1:0] pi_nxt, g_nxt;

    assign in_ready_o = (state == IDLE) || (state == LOAD);

    // Incremental QPP address: both sums stay below 2K, so one conditional subtract wraps them.
    always_comb begin
        pi_sum = {1'b0, pi_q} + {1'b0, g_q};
        g_sum  = {1'b0, g_q} + {1'b0, G_STEP};
        pi_nxt = (pi_sum >= K_X) ? (pi_q + g_q - K_LO) : (pi_q + g_q);
        g_nxt  = (g_sum >= K_X) ? (g_q + G_STEP - K_LO) : (g_q + G_STEP);
    end

    always_comb begin
        u1 = data_buf[cnt];
        u2 = data_buf[pi_q];
`ifdef TURBO_ENC_TAIL_EN
        // Feeding back d2^d3 zeroes the recursion input, flushing the register.
        if (state == TAIL1) u1 = r1[1] ^ r1[2];
        if (state == TAIL2) u2 = r2[1] ^ r2[2];
`endif
        a1 = u1 ^ r1[1] ^ r1[2];
        a2 = u2 ^ r2[1] ^ r2[2];
        z1 = a1 ^ r1[0] ^ r1[2];
        z2 = a2 ^ r2[0] ^ r2[2];
    end

    always_comb begin
        out_valid_o = 1'b0;
        sys_o       = 1'b0;
        par1_o      = 1'b0;
        par2_o      = 1'b0;
        last_o      = 1'b0;
        case (state)
            ENC: begin
                out_valid_o = 1'b1;
                sys_o       = u1;
                par1_o      = z1;
                par2_o      = z2;
`ifndef TURBO_ENC_TAIL_EN
                last_o      = (cnt == K_LAST);
`endif
            end
`ifdef TURBO_ENC_TAIL_EN
            TAIL1: begin
                out_valid_o = 1'b1;
                sys_o       = u1;
                par1_o      = z1;
            end
            TAIL2: begin
                out_valid_o = 1'b1;
                sys_o       = u2;
                par2_o      = z2;
                last_o      = (cnt == CW'(2));
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_p_i) begin
        if (in_valid_i && in_ready_o) begin
            data_buf[cnt] <= data_i;
        end
    end

    always_ff @(posedge clk_p_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
            cnt   <= '0;
            pi_q  <= '0;
            g_q   <= G0;
            r1    <= '0;
            r2    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        state <= LOAD;
                        cnt   <= CW'(1);
                    end
                end
                LOAD: begin
                    if (in_valid_i) begin
                        if (cnt == K_LAST) begin
                            state <= ENC;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ENC: begin
                    if (out_ready_i) begin
                        r1   <= {r1[1:0], a1};
                        r2   <= {r2[1:0], a2};
                        pi_q <= pi_nxt;
                        g_q  <= g_nxt;
                        if (cnt == K_LAST) begin
`ifdef TURBO_ENC_TAIL_EN
                            state <= TAIL1;
                            cnt   <= '0;
`else
                            state <= IDLE;
                            cnt   <= '0;
                            pi_q  <= '0;
                            g_q   <= G0;
                            r1    <= '0;
                            r2    <= '0;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
`ifdef TURBO_ENC_TAIL_EN
                TAIL1: begin
                    if (out_ready_i) begin
                        r1 <= {r1[1:0], a1};
                        if (cnt == CW'(2)) begin
                            state <= TAIL2;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                TAIL2: begin
                    if (out_ready_i) begin
                        r2 <= {r2[1:0], a2};
                        if (cnt == CW'(2)) begin
                            state <= IDLE;
                            cnt   <= '0;
                            pi_q  <= '0;
                            g_q   <= G0;
                            r1    <= '0;
                            r2    <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
